// File: rtl/nbit_cmp_pkg.sv
// Shared types and sizing helpers for the nbit_comparator slice chain.
package nbit_cmp_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } cmp_res_t;

  // Operand width rounded up to a whole number of slices.
  function automatic int unsigned pad_width(input int unsigned w);
    return ((w + SLICE_W - 1) / SLICE_W) * SLICE_W;
  endfunction

endpackage

// File: rtl/nbit_cmp_slice.sv
// One 4-bit magnitude compare stage with 7485-style cascade inputs.
module nbit_cmp_slice
  import nbit_cmp_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               gt_in,
  input  logic               eq_in,
  input  logic               lt_in,
  output logic               gt,
  output logic               eq,
  output logic               lt
);

  // A local inequality decides; only an equal nibble defers to lower slices.
  always_comb begin
    gt = 1'b0;
    eq = 1'b0;
    lt = 1'b0;
    if (a > b) begin
      gt = 1'b1;
    end else if (a < b) begin
      lt = 1'b1;
    end else begin
      gt = gt_in;
      eq = eq_in;
      lt = lt_in;
    end
  end

endmodule

// File: rtl/nbit_comparator.sv
// Registered WIDTH-bit magnitude comparator built from cascaded 4-bit slices.
// Define NBIT_CMP_SIGNED_EN to add the sgn port for per-transaction signed compares.
module nbit_comparator
  import nbit_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef NBIT_CMP_SIGNED_EN
  input  logic             sgn,
`endif
  output logic             out_valid,
  output logic             y2,
  output logic             y1,
  output logic             y0
);

  localparam int unsigned PAD_W  = pad_width(WIDTH);
  localparam int unsigned NSLICE = PAD_W / SLICE_W;

  logic [WIDTH-1:0] a_m;
  logic [WIDTH-1:0] b_m;
  logic [PAD_W-1:0] a_p;
  logic [PAD_W-1:0] b_p;
  cmp_res_t         res_c;
  cmp_res_t         res_d;
  cmp_res_t         res_q;
  logic             valid_q;

`ifdef NBIT_CMP_SIGNED_EN
  // Flipping both MSBs maps two's-complement ordering onto unsigned ordering.
  always_comb begin
    a_m            = a;
    b_m            = b;
    a_m[WIDTH-1]   = a[WIDTH-1] ^ sgn;
    b_m[WIDTH-1]   = b[WIDTH-1] ^ sgn;
  end
`else
  assign a_m = a;
  assign b_m = b;
`endif

  // Pads are added after the MSB flip so they are identical on both sides.
  assign a_p = PAD_W'(a_m);
  assign b_p = PAD_W'(b_m);

  for (genvar i = 0; i < int'(NSLICE); i++) begin : g_slice
    cmp_res_t cin;
    cmp_res_t cout;

    if (i == 0) begin : g_lsb
      assign cin = '{gt: 1'b0, eq: 1'b1, lt: 1'b0};
    end else begin : g_upper
      assign cin = g_slice[i-1].cout;
    end

    nbit_cmp_slice u_slice (
      .a     (a_p[i*SLICE_W +: SLICE_W]),
      .b     (b_p[i*SLICE_W +: SLICE_W]),
      .gt_in (cin.gt),
      .eq_in (cin.eq),
      .lt_in (cin.lt),
      .gt    (cout.gt),
      .eq    (cout.eq),
      .lt    (cout.lt)
    );
  end

  assign res_c = g_slice[NSLICE-1].cout;

  always_comb begin
    res_d = res_q;
    if (in_valid) begin
      res_d = res_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      res_q   <= res_d;
      valid_q <= in_valid;
    end
  end

  assign out_valid = valid_q;
  assign y2        = res_q.gt;
  assign y1        = res_q.eq;
  assign y0        = res_q.lt;

endmodule

// File: tb/tb_nbit_comparator.sv
// Scoreboard bench for nbit_comparator at WIDTH=4 and WIDTH=10 driven in lockstep.
module tb_nbit_comparator;

`ifdef NBIT_CMP_SIGNED_EN
  localparam bit SGN_EN = 1'b1;
`else
  localparam bit SGN_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       sgn;
  logic [3:0] a4, b4;
  logic [9:0] a10, b10;
  logic       ov4, y2_4, y1_4, y0_4;
  logic       ov10, y2_10, y1_10, y0_10;

  logic [2:0] q4[$];
  logic [2:0] q10[$];
  logic [2:0] hold4  = 3'b000;
  logic [2:0] hold10 = 3'b000;
  int         n_chk  = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  nbit_comparator #(.WIDTH(4)) u_w4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a4),
    .b         (b4),
`ifdef NBIT_CMP_SIGNED_EN
    .sgn       (sgn),
`endif
    .out_valid (ov4),
    .y2        (y2_4),
    .y1        (y1_4),
    .y0        (y0_4)
  );

  nbit_comparator #(.WIDTH(10)) u_w10 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a10),
    .b         (b10),
`ifdef NBIT_CMP_SIGNED_EN
    .sgn       (sgn),
`endif
    .out_valid (ov10),
    .y2        (y2_10),
    .y1        (y1_10),
    .y0        (y0_10)
  );

  // Reference: interpret operands as integers and order them; returns {gt,eq,lt}.
  function automatic logic [2:0] model(input longint unsigned av, input longint unsigned bv,
                                       input int w, input bit s);
    longint sa, sb;
    sa = longint'(av);
    sb = longint'(bv);
    if (s && av[w-1]) sa = sa - (longint'(1) << w);
    if (s && bv[w-1]) sb = sb - (longint'(1) << w);
    if (sa > sb)       return 3'b100;
    else if (sa == sb) return 3'b010;
    else               return 3'b001;
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got ov,gt,eq,lt=%b required %b at %0t", nm, act, exp, $time);
  endtask

  task automatic issue(input bit r, input bit v, input bit s,
                       input logic [3:0] x4, input logic [3:0] z4,
                       input logic [9:0] x10, input logic [9:0] z10);
    @(negedge clk);
    rst = r; in_valid = v; sgn = s;
    a4 = x4; b4 = z4; a10 = x10; b10 = z10;
    if (v && !r) begin
      q4.push_back(model(64'(x4), 64'(z4), 4, s && SGN_EN));
      q10.push_back(model(64'(x10), 64'(z10), 10, s && SGN_EN));
    end
  endtask

  // Monitor: classify the edge just taken and compare the registered outputs.
  always @(posedge clk) begin : mon
    bit         r_s, v_s;
    logic [2:0] e;
    r_s = rst;
    v_s = in_valid;
    #1;
    if (r_s) begin
      chk("reset_w4",  {ov4,  y2_4,  y1_4,  y0_4},  4'b0000);
      chk("reset_w10", {ov10, y2_10, y1_10, y0_10}, 4'b0000);
      hold4  = 3'b000;
      hold10 = 3'b000;
    end else if (v_s) begin
      if (q4.size() == 0 || q10.size() == 0) begin
        n_chk++;
        $display("FAIL sb_underflow: out_valid with no expected entry at %0t", $time);
      end else begin
        e = q4.pop_front();
        chk("cmp_w4", {ov4, y2_4, y1_4, y0_4}, {1'b1, e});
        hold4 = e;
        e = q10.pop_front();
        chk("cmp_w10", {ov10, y2_10, y1_10, y0_10}, {1'b1, e});
        hold10 = e;
      end
    end else begin
      chk("hold_w4",  {ov4,  y2_4,  y1_4,  y0_4},  {1'b0, hold4});
      chk("hold_w10", {ov10, y2_10, y1_10, y0_10}, {1'b0, hold10});
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; sgn = 1'b0;
    a4 = '0; b4 = '0; a10 = '0; b10 = '0;

    // Reset held two cycles with valid operands present.
    repeat (2) issue(1, 1, 0, 4'($urandom), 4'($urandom), 10'($urandom), 10'($urandom));

    // Directed unsigned table, wide-cascade cases alongside.
    issue(0, 1, 0, 4'b1000, 4'b1010, 10'h200, 10'h1FF);
    issue(0, 1, 0, 4'b0100, 4'b1011, 10'h3FF, 10'h3FF);
    issue(0, 1, 0, 4'b1111, 4'b1100, 10'h0FF, 10'h100);
    issue(0, 1, 0, 4'b0011, 4'b1111, 10'h001, 10'h000);

    // Equality then hold with changed operands.
    issue(0, 1, 0, 4'b0110, 4'b0110, 10'h155, 10'h155);
    issue(0, 0, 0, 4'b1111, 4'b0000, 10'h3FF, 10'h000);
    issue(0, 0, 0, 4'b0000, 4'b1111, 10'h000, 10'h3FF);

    // Signed pairs, then the same pairs unsigned.
    issue(0, 1, 1, 4'b1111, 4'b0001, 10'h3FF, 10'h001);
    issue(0, 1, 1, 4'b0111, 4'b1000, 10'h1FF, 10'h200);
    issue(0, 1, 0, 4'b1111, 4'b0001, 10'h3FF, 10'h001);
    issue(0, 1, 0, 4'b0111, 4'b1000, 10'h1FF, 10'h200);

    // Reset on the same edge as a valid compare; result must be discarded.
    issue(0, 1, 0, 4'b1001, 4'b0001, 10'h300, 10'h001);
    issue(1, 1, 0, 4'b0001, 4'b1001, 10'h001, 10'h300);
    issue(0, 0, 0, 4'b0001, 4'b1001, 10'h001, 10'h300);
    issue(0, 1, 0, 4'b0101, 4'b0101, 10'h0F0, 10'h10F);

    // Randomized traffic with occasional resets and idle cycles.
    for (int i = 0; i < 400; i++) begin
      bit r, v, s;
      r = ($urandom_range(0, 24) == 0);
      v = ($urandom_range(0, 3) != 0);
      s = 1'($urandom);
      if ($urandom_range(0, 7) == 0)
        issue(r, v, s, 4'($urandom), 4'($urandom), 10'($urandom), 10'($urandom));
      else begin
        logic [3:0] x4;
        logic [9:0] x10;
        x4  = 4'($urandom);
        x10 = 10'($urandom);
        issue(r, v, s, x4, ($urandom_range(0, 2) == 0) ? x4 : 4'($urandom),
              x10, ($urandom_range(0, 2) == 0) ? x10 : 10'($urandom));
      end
    end

    repeat (3) issue(0, 0, 0, '0, '0, '0, '0);
    @(posedge clk);
    #2;

    n_chk++;
    if (q4.size() == 0 && q10.size() == 0) n_pass++;
    else $display("FAIL sb_drain: got %0d/%0d pending entries, required 0/0", q4.size(), q10.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
